// File: rtl/apb_slave_regs.sv
// APB completer with a small bank of 32-bit control/status registers.
// Reg 0 is a read-only ID word; regs 1..NUM_REGS-1 are read/write.
// A fixed number of wait states is inserted before PREADY. Bad accesses
// (misaligned, out of range, or a write to the ID register) set PSLVERR.
module apb_slave_regs #(
    parameter int unsigned     ADDR_W      = 8,
    parameter int unsigned     DATA_W      = 32,
    parameter int unsigned     NUM_REGS    = 8,
    parameter int unsigned     WAIT_STATES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE  = 32'hA9B0_0001
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_write;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_err;
    logic [DATA_W-1:0]  r_prdata;
    logic               r_pslverr;
    logic [DATA_W-1:0]  r_regs [1:NUM_REGS-1];

    logic [IDX_W-1:0]   w_idx;
    logic               w_err;
    logic               w_setup;
    logic               w_start;
    logic               w_commit;
    logic [DATA_W-1:0]  w_rdata;
    logic [NUM_REGS-1:1] w_we;

    // Decode of the address presented during the setup phase
    assign w_idx   = PADDR[ADDR_W-1:2];
    assign w_err   = (PADDR[1:0] != 2'b00)
                   | (32'(w_idx) >= NUM_REGS)
                   | (PWRITE & (w_idx == '0));
    assign w_setup = PSEL & ~PENABLE;
    // A new transfer only starts from IDLE or DONE; a setup seen while in
    // ACCESS belongs to nothing and is ignored.
    assign w_start = w_setup & (r_state != ST_ACCESS);

    assign PREADY   = (r_state == ST_ACCESS) && (r_cnt == WS);
    assign w_commit = (r_state == ST_ACCESS) & PSEL & PENABLE & PREADY;
    assign PRDATA   = r_prdata;
    assign PSLVERR  = r_pslverr;

    // Per-register write enables; the decode was frozen at the setup edge
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_we
        assign w_we[gi] = w_commit & r_write & ~r_err & (r_idx == IDX_W'(gi));
    end

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state logic: IDLE -> ACCESS -> DONE, with abort on PSEL loss
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!PSEL)         w_state_next = ST_IDLE;
                else if (w_commit) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (w_setup)   w_state_next = ST_ACCESS;
                else if (!PSEL) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Latch the transfer on the setup edge and count wait states
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else if (w_start) begin
            r_cnt   <= '0;
            r_idx   <= w_idx;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_err   <= w_err;
        end else if ((r_state == ST_ACCESS) && PSEL && (r_cnt < WS)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Read mux; reg 0 is the constant ID word
    always_comb begin
        w_rdata = ID_VALUE;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (r_idx == IDX_W'(i)) w_rdata = r_regs[i];
        end
    end

    // Register bank update on a good write commit
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (w_we[i]) r_regs[i] <= r_wdata;
            end
        end
    end

    // Response outputs change only on a commit and hold until the next one
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else if (w_commit) begin
            r_pslverr <= r_err;
            if (!r_write) r_prdata <= r_err ? '0 : w_rdata;
        end
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench for apb_slave_regs: directed scenarios plus a random
// burst, all checked against a register-level model of the block.
module tb_apb_slave_regs;

    localparam int          WS = 1;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_tests = 0;
    int n_fails = 0;

    // Reference model state
    logic [31:0] m_regs [0:7];
    logic [31:0] m_prdata;
    logic        m_pslverr;

    // Results of the last transfer
    logic [31:0] got_rd;
    logic        got_err;
    int          got_waits;
    logic        got_done_ready;

    apb_slave_regs #(
        .ADDR_W(8), .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(WS), .ID_VALUE(ID)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
        m_prdata  = 32'h0;
        m_pslverr = 1'b0;
    endtask

    // Architectural effect of one completed transfer
    task automatic model_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
        int  idx;
        bit  err;
        idx = int'(addr) / 4;
        err = (int'(addr) % 4 != 0) || (idx >= 8) || (wr && idx == 0);
        if (!wr) m_prdata = err ? 32'h0 : ((idx == 0) ? ID : m_regs[idx]);
        else if (!err) m_regs[idx] = wdata;
        m_pslverr = err;
    endtask

    // Master: called #1 after an edge; returns just after the commit edge
    // (plus one more cycle with PSEL/PENABLE held when extra is set).
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input bit extra);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE   = 1'b1;
        got_waits = 0;
        while (PREADY !== 1'b1 && got_waits < 20) begin
            @(posedge PCLK); #1;
            got_waits++;
        end
        n_tests++;
        if (got_waits >= 20) begin
            n_fails++;
            $display("FAIL pready_timeout: got PREADY=%b after %0d cycles, need 1", PREADY, got_waits);
        end
        @(posedge PCLK); #1;
        got_rd         = PRDATA;
        got_err        = PSLVERR;
        got_done_ready = PREADY;
        if (extra) begin
            @(posedge PCLK); #1;
            got_done_ready = got_done_ready | PREADY;
        end
        $display("[TB] %s addr=0x%02h wdata=0x%08h rdata=0x%08h err=%0b waits=%0d",
                 wr ? "WR" : "RD", addr, wdata, got_rd, got_err, got_waits);
    endtask

    task automatic apb_idle();
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic run_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input bit extra, input bit b2b);
        model_xfer(wr, addr, wdata);
        apb_xfer(wr, addr, wdata, extra);
        if (!b2b) apb_idle();
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 32'h0;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        n_tests++;
        if (PRDATA !== 32'h0) begin n_fails++; $display("FAIL reset_prdata: got %h need 0", PRDATA); end
        n_tests++;
        if (PREADY !== 1'b0) begin n_fails++; $display("FAIL reset_pready: got %b need 0", PREADY); end
        n_tests++;
        if (PSLVERR !== 1'b0) begin n_fails++; $display("FAIL reset_pslverr: got %b need 0", PSLVERR); end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        run_xfer(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (got_rd !== ID) begin n_fails++; $display("FAIL id_read: got %h need %h", got_rd, ID); end
        n_tests++;
        if (got_err !== 1'b0) begin n_fails++; $display("FAIL id_err: got %b need 0", got_err); end
    endtask

    task automatic test_write_read();
        run_xfer(1'b1, 8'h04, 32'hDEADBEEF, 1'b0, 1'b0);
        n_tests++;
        if (got_waits != WS) begin n_fails++; $display("FAIL wr_waits: got %0d need %0d", got_waits, WS); end
        n_tests++;
        if (got_done_ready !== 1'b0) begin n_fails++; $display("FAIL wr_ready_after: got %b need 0", got_done_ready); end
        n_tests++;
        if (got_err !== 1'b0) begin n_fails++; $display("FAIL wr_err: got %b need 0", got_err); end
        run_xfer(1'b0, 8'h04, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (got_rd !== m_prdata) begin n_fails++; $display("FAIL rd_04: got %h need %h", got_rd, m_prdata); end
        n_tests++;
        if (got_err !== m_pslverr) begin n_fails++; $display("FAIL rd_04_err: got %b need %b", got_err, m_pslverr); end
    endtask

    task automatic test_errors();
        run_xfer(1'b1, 8'h40, 32'h12345678, 1'b0, 1'b0);
        n_tests++;
        if (got_err !== 1'b1) begin n_fails++; $display("FAIL oor_wr_err: got %b need 1", got_err); end
        run_xfer(1'b0, 8'h40, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (got_rd !== 32'h0 || got_err !== 1'b1) begin
            n_fails++; $display("FAIL oor_rd: got %h/%b need 00000000/1", got_rd, got_err);
        end
        for (int i = 1; i < 8; i++) begin
            run_xfer(1'b0, 8'(4 * i), 32'h0, 1'b0, 1'b0);
            n_tests++;
            if (got_rd !== m_prdata) begin n_fails++; $display("FAIL reg%0d_unchanged: got %h need %h", i, got_rd, m_prdata); end
        end
        run_xfer(1'b1, 8'h00, 32'hFFFFFFFF, 1'b0, 1'b0);
        n_tests++;
        if (got_err !== 1'b1) begin n_fails++; $display("FAIL ro_wr_err: got %b need 1", got_err); end
        run_xfer(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (got_rd !== ID) begin n_fails++; $display("FAIL ro_id: got %h need %h", got_rd, ID); end
        run_xfer(1'b1, 8'h05, 32'h55555555, 1'b0, 1'b0);
        n_tests++;
        if (got_err !== 1'b1) begin n_fails++; $display("FAIL misalign_err: got %b need 1", got_err); end
        run_xfer(1'b0, 8'h04, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (got_rd !== m_prdata || got_err !== 1'b0) begin
            n_fails++; $display("FAIL misalign_reg1: got %h/%b need %h/0", got_rd, got_err, m_prdata);
        end
    endtask

    task automatic test_abort_and_reset();
        logic [31:0] held_rd;
        logic        held_err;
        held_rd  = PRDATA;
        held_err = PSLVERR;
        // Abort during the wait state: PSEL drops before PREADY rises
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'hCAFEF00D;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n_tests++;
        if (PREADY !== 1'b0) begin n_fails++; $display("FAIL abort_wait_state: got PREADY=%b need 0", PREADY); end
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        $display("[TB] ABORT addr=0x08 wdata=0xcafef00d");
        n_tests++;
        if (PRDATA !== held_rd || PSLVERR !== held_err || PREADY !== 1'b0) begin
            n_fails++; $display("FAIL abort_outputs: got %h/%b/%b need %h/%b/0", PRDATA, PSLVERR, PREADY, held_rd, held_err);
        end
        run_xfer(1'b0, 8'h08, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (got_rd !== 32'h0) begin n_fails++; $display("FAIL abort_no_commit: got %h need 0", got_rd); end
        run_xfer(1'b0, 8'h04, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (got_rd !== m_prdata) begin n_fails++; $display("FAIL pre_reset_04: got %h need %h", got_rd, m_prdata); end
        // Reset asserted while PREADY is high in a write
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C; PWDATA = 32'h11223344;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        #2 PRESETn = 1'b0;
        #1;
        model_reset();
        $display("[TB] RESET mid-write addr=0x0c");
        n_tests++;
        if (PREADY !== 1'b0 || PRDATA !== 32'h0 || PSLVERR !== 1'b0) begin
            n_fails++; $display("FAIL midwrite_reset: got %b/%h/%b need 0/0/0", PREADY, PRDATA, PSLVERR);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        run_xfer(1'b0, 8'h04, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (got_rd !== 32'h0) begin n_fails++; $display("FAIL post_reset_04: got %h need 0", got_rd); end
        run_xfer(1'b0, 8'h0C, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (got_rd !== 32'h0) begin n_fails++; $display("FAIL dropped_write_0c: got %h need 0", got_rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int k = 0; k < 3; k++) begin
            v = $urandom;
            run_xfer(1'b1, 8'h0C, v, 1'b1, 1'b1);
            n_tests++;
            if (got_done_ready !== 1'b0) begin n_fails++; $display("FAIL b2b_wr_ready_in_done: got %b need 0", got_done_ready); end
            run_xfer(1'b0, 8'h0C, 32'h0, 1'b1, 1'b1);
            n_tests++;
            if (got_rd !== m_prdata || got_err !== 1'b0) begin
                n_fails++; $display("FAIL b2b_rd: got %h/%b need %h/0", got_rd, got_err, m_prdata);
            end
            n_tests++;
            if (got_done_ready !== 1'b0) begin n_fails++; $display("FAIL b2b_rd_ready_in_done: got %b need 0", got_done_ready); end
        end
        apb_idle();
    endtask

    task automatic test_random();
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          r;
        bit          extra;
        bit          b2b;
        for (int k = 0; k < 60; k++) begin
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            r     = $urandom_range(0, 9);
            if (r < 8)       addr = 8'(4 * r);
            else if (r == 8) addr = 8'($urandom_range(0, 255));
            else             addr = 8'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
            extra = 1'($urandom_range(0, 1));
            b2b   = 1'($urandom_range(0, 1));
            run_xfer(wr, addr, wdata, extra, b2b);
            n_tests++;
            if (got_rd !== m_prdata || got_err !== m_pslverr) begin
                n_fails++; $display("FAIL rand_%0d: got %h/%b need %h/%b", k, got_rd, got_err, m_prdata, m_pslverr);
            end
            n_tests++;
            if (got_waits != WS || got_done_ready !== 1'b0) begin
                n_fails++; $display("FAIL rand_timing_%0d: got waits=%0d ready_done=%b need %0d/0", k, got_waits, got_done_ready, WS);
            end
        end
        apb_idle();
        for (int i = 1; i < 8; i++) begin
            run_xfer(1'b0, 8'(4 * i), 32'h0, 1'b0, 1'b0);
            n_tests++;
            if (got_rd !== m_regs[i]) begin n_fails++; $display("FAIL final_reg%0d: got %h need %h", i, got_rd, m_regs[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_abort_and_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
